// File: rtl/cardio_pkg.sv
// Shared types and helpers for the streaming cardio risk scorer.
package cardio_pkg;

  localparam int unsigned MODE_W = 2;
  localparam int unsigned SAT_W  = 16;

  typedef enum logic [MODE_W-1:0] {
    MODE_OFF  = 2'b00,
    MODE_GT   = 2'b01,
    MODE_LT   = 2'b10,
    MODE_FLAG = 2'b11
  } mode_e;

  typedef enum logic {
    ACCUM = 1'b0,
    DONE  = 1'b1
  } state_e;

  // Increment by inc, clamping at max.
  function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                               input logic             inc,
                                               input logic [SAT_W-1:0] max);
    logic [SAT_W-1:0] r;
    r = a;
    if (inc && (a < max)) r = a + SAT_W'(1);
    return r;
  endfunction

endpackage

// File: rtl/cardio_feat_eval.sv
// Evaluates one reconstructed feature value against its configured rule.
module cardio_feat_eval
  import cardio_pkg::*;
#(
  parameter int unsigned FEAT_W = 8
) (
  input  logic [FEAT_W-1:0] value,
  input  mode_e             mode,
  input  logic [FEAT_W-1:0] thr,
  output logic              hit
);

  always_comb begin
    hit = 1'b0;
    unique case (mode)
      MODE_OFF:  hit = 1'b0;
      MODE_GT:   hit = (value > thr);
      MODE_LT:   hit = (value < thr);
      MODE_FLAG: hit = value[0];
      default:   hit = 1'b0;
    endcase
  end

endmodule

// File: rtl/cardio_score_stream.sv
// Streams XOR-shared features, one per beat, and accumulates a saturating
// per-record risk score with valid/ready handshakes on both sides.
module cardio_score_stream
  import cardio_pkg::*;
#(
  parameter int unsigned NUM_FEAT = 7,
  parameter int unsigned FEAT_W   = 8,
  parameter int unsigned SCORE_W  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2*NUM_FEAT-1:0]      cfg_mode,
  input  logic [FEAT_W*NUM_FEAT-1:0] cfg_thr,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FEAT_W-1:0]          in_share_a,
  input  logic [FEAT_W-1:0]          in_share_b,
  input  logic                       in_last,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [SCORE_W-1:0]         out_score,
  output logic                       out_err
);

  localparam int unsigned IDX_W = $clog2(NUM_FEAT + 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [SCORE_W-1:0] acc_q, acc_d;
  logic               err_q, err_d;

  mode_e              cur_mode;
  logic [FEAT_W-1:0]  cur_thr;
  logic [FEAT_W-1:0]  value;
  logic               hit;
  logic               beat;
  logic               overflow;

  // Rule select by idx; overflow beats fall through to the disabled default.
  always_comb begin
    cur_mode = MODE_OFF;
    cur_thr  = '0;
    for (int i = 0; i < int'(NUM_FEAT); i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_mode = mode_e'(cfg_mode[2*i +: 2]);
        cur_thr  = cfg_thr[FEAT_W*i +: FEAT_W];
      end
    end
  end

  assign value = in_share_a ^ in_share_b;

  cardio_feat_eval #(.FEAT_W(FEAT_W)) u_eval (
    .value (value),
    .mode  (cur_mode),
    .thr   (cur_thr),
    .hit   (hit)
  );

  assign in_ready = (state_q == ACCUM) & ~rst;
  assign beat     = in_valid & in_ready;
  assign overflow = (idx_q == IDX_W'(NUM_FEAT));

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    acc_d   = acc_q;
    err_d   = err_q;
    unique case (state_q)
      ACCUM: begin
        if (beat) begin
          acc_d = SCORE_W'(sat_add(SAT_W'(acc_q), hit, SAT_W'(SCORE_MAX)));
          if (overflow) err_d = 1'b1;
          else          idx_d = idx_q + IDX_W'(1);
          if (in_last) begin
            if (idx_q != IDX_W'(NUM_FEAT - 1)) err_d = 1'b1;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = ACCUM;
          idx_d   = '0;
          acc_d   = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ACCUM;
      idx_q   <= '0;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end

  // Result registers are presented directly; reset forces the idle view.
  assign out_valid = (state_q == DONE) & ~rst;
  assign out_score = rst ? '0 : acc_q;
  assign out_err   = err_q & ~rst;

endmodule
